// File: rtl/output_forward.sv
// output_forward: output neuron MAC over N_HIDDEN hidden/weight beats with a saturating sum (optional bias via OUTPUT_FORWARD_BIAS_EN)
module output_forward #(
    parameter int N_HIDDEN  = 4,
    parameter int H_WIDTH   = 10,
    parameter int W_WIDTH   = 8,
    parameter int ACC_WIDTH = 23
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 clear_i,
    input  logic                 valid_i,
    input  logic [H_WIDTH-1:0]   hidden_val_i,
    input  logic [W_WIDTH-1:0]   w_i,
`ifdef OUTPUT_FORWARD_BIAS_EN
    input  logic [W_WIDTH-1:0]   bias_i,
`endif
    output logic                 ready_o,
    output logic                 busy_o,
    output logic [ACC_WIDTH-1:0] final_o,
    output logic                 done_o,
    output logic                 sat_o
);
    localparam int CW = $clog2(N_HIDDEN) + 1;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                       state;
    logic [ACC_WIDTH-1:0]         acc;
    logic [CW-1:0]                cnt;
    logic [H_WIDTH+W_WIDTH-1:0]   prod;
    logic [ACC_WIDTH:0]           sum;
    logic [ACC_WIDTH-1:0]         acc_nxt;
    logic [ACC_WIDTH-1:0]         acc_init;
    logic                         accept;
    logic                         last;

    assign prod    = hidden_val_i * w_i;
    assign sum     = {1'b0, acc} + (ACC_WIDTH+1)'(prod);
    assign acc_nxt = sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
    assign accept  = valid_i & ready_o;
    assign last    = cnt == CW'(N_HIDDEN - 1);
`ifdef OUTPUT_FORWARD_BIAS_EN
    assign acc_init = ACC_WIDTH'(bias_i);
`else
    assign acc_init = '0;
`endif

    // pass sequencing, accumulation and registered handshake/status outputs
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            final_o <= '0;
            done_o  <= 1'b0;
            sat_o   <= 1'b0;
            ready_o <= 1'b0;
            busy_o  <= 1'b0;
        end else if (clear_i) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            done_o  <= 1'b0;
            ready_o <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_i) begin
                    state   <= ACCUM;
                    acc     <= acc_init;
                    cnt     <= '0;
                    sat_o   <= 1'b0;
                    ready_o <= 1'b1;
                    busy_o  <= 1'b1;
                end
                ACCUM: if (accept) begin
                    acc <= acc_nxt;
                    cnt <= cnt + 1'b1;
                    if (sum[ACC_WIDTH]) sat_o <= 1'b1;
                    if (last) begin
                        state   <= DONE;
                        final_o <= acc_nxt;
                        ready_o <= 1'b0;
                        done_o  <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_output_forward.sv
// tb_output_forward: scoreboard bench for output_forward, default and N_HIDDEN=8/ACC_WIDTH=20 instances
module tb_output_forward;
    logic        clk = 0, rst_i = 0, clear = 0, valid = 0, start0 = 0, start1 = 0;
    logic [9:0]  h = 0;
    logic [7:0]  w = 0, bias = 0;
    logic        r0, b0, d0, s0, r1, b1, d1, s1;
    logic [22:0] f0;
    logic [19:0] f1;
    logic [9:0]  ha[8];
    logic [7:0]  wa[8];
    int          cyc = 0, total = 0, bad = 0, st0 = 0, st1 = 0;

    typedef struct {logic [22:0] fin; logic sat; int lat;} exp_t;
    exp_t q0[$], q1[$];
    exp_t e0, e1;

    output_forward u0 (
        .clk_i(clk), .rst_i(rst_i), .start_i(start0), .clear_i(clear), .valid_i(valid),
        .hidden_val_i(h), .w_i(w),
`ifdef OUTPUT_FORWARD_BIAS_EN
        .bias_i(bias),
`endif
        .ready_o(r0), .busy_o(b0), .final_o(f0), .done_o(d0), .sat_o(s0)
    );

    output_forward #(.N_HIDDEN(8), .ACC_WIDTH(20)) u1 (
        .clk_i(clk), .rst_i(rst_i), .start_i(start1), .clear_i(clear), .valid_i(valid),
        .hidden_val_i(h), .w_i(w),
`ifdef OUTPUT_FORWARD_BIAS_EN
        .bias_i(bias),
`endif
        .ready_o(r1), .busy_o(b1), .final_o(f1), .done_o(d1), .sat_o(s1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start0 = v;
        else start1 = v;
    endtask

    // one pass; clr_at>=0 aborts with clear on that beat, gap_at>=0 idles two cycles after that beat
    task automatic pass(input int sel, input int n, input int gap_at, input int clr_at,
                        input logic hold_start, input logic [22:0] ef, input logic es);
        if (clr_at < 0) begin
            if (sel == 0) q0.push_back('{ef, es, n + 1 + ((gap_at >= 0) ? 2 : 0)});
            else q1.push_back('{ef, es, n + 1 + ((gap_at >= 0) ? 2 : 0)});
        end
        step();
        set_start(sel, 1'b1);
        if (sel == 0) st0 = cyc;
        else st1 = cyc;
        for (int i = 0; i < n; i++) begin
            step();
            set_start(sel, hold_start);
            valid = 1;
            h = ha[i];
            w = wa[i];
            if (i == clr_at) begin
                clear = 1;
                step();
                clear = 0;
                valid = 0;
                chk("clear_idle", (sel == 0) ? b0 : b1, 0);
                chk("clear_ready", (sel == 0) ? r0 : r1, 0);
                step();
                return;
            end
            if (i == gap_at) begin
                step();
                valid = 0;
                chk("gap_ready_a", (sel == 0) ? r0 : r1, 1);
                step();
                chk("gap_ready_b", (sel == 0) ? r0 : r1, 1);
            end
        end
        step();
        valid = 0;
        step();
        set_start(sel, 1'b0);
        step();
        chk("no_restart", (sel == 0) ? b0 : b1, 0);
        step();
    endtask

    // scoreboard monitor for the default instance
    always @(negedge clk) if (d0 === 1'b1) begin
        if (q0.size() == 0) chk("unexpected_done0", 1, 0);
        else begin
            e0 = q0.pop_front();
            chk("final0", 32'(f0), 32'(e0.fin));
            chk("sat0", 32'(s0), 32'(e0.sat));
            chk("lat0", cyc - st0, e0.lat);
        end
    end

    // scoreboard monitor for the wide instance
    always @(negedge clk) if (d1 === 1'b1) begin
        if (q1.size() == 0) chk("unexpected_done1", 1, 0);
        else begin
            e1 = q1.pop_front();
            chk("final1", 32'(f1), 32'(e1.fin));
            chk("sat1", 32'(s1), 32'(e1.sat));
            chk("lat1", cyc - st1, e1.lat);
        end
    end

    initial begin
        #3;
        chk("rst_ready", r0, 0);
        chk("rst_busy", b0, 0);
        chk("rst_done", d0, 0);
        chk("rst_sat", s0, 0);
        chk("rst_final", 32'(f0), 0);
        chk("rst_busy1", b1, 0);
        #10 rst_i = 1;
        ha = '{1, 2, 3, 4, 0, 0, 0, 0};
        wa = '{5, 6, 7, 8, 0, 0, 0, 0};
        pass(0, 4, -1, -1, 0, 70, 0);
        pass(0, 4, 1, -1, 0, 70, 0);
        pass(0, 4, -1, -1, 1, 70, 0);
        ha = '{default: 10'd1023};
        wa = '{default: 8'd255};
        pass(1, 8, -1, -1, 0, 1048575, 1);
        ha = '{default: 10'd0};
        wa = '{default: 8'd0};
        pass(1, 8, -1, -1, 0, 0, 0);
        ha = '{2, 2, 2, 2, 0, 0, 0, 0};
        wa = '{1, 1, 1, 1, 0, 0, 0, 0};
        pass(0, 4, -1, 2, 0, 0, 0);
        chk("clear_keeps_final", 32'(f0), 70);
        pass(0, 4, -1, 3, 0, 0, 0);
        chk("clear_last_keeps_final", 32'(f0), 70);
        ha = '{1, 2, 3, 4, 0, 0, 0, 0};
        wa = '{5, 6, 7, 8, 0, 0, 0, 0};
        pass(0, 4, -1, -1, 0, 70, 0);
`ifdef OUTPUT_FORWARD_BIAS_EN
        bias = 10;
        pass(0, 4, -1, -1, 0, 80, 0);
        bias = 0;
`endif
        step();
        start0 = 1;
        step();
        start0 = 0;
        valid = 1;
        h = 1;
        w = 5;
        step();
        step();
        #2 rst_i = 0;
        #1;
        chk("async_rst_ready", r0, 0);
        chk("async_rst_busy", b0, 0);
        chk("async_rst_final", 32'(f0), 0);
        chk("async_rst_sat", s0, 0);
        chk("async_rst_done", d0, 0);
        valid = 0;
        step();
        rst_i = 1;
        pass(0, 4, -1, -1, 0, 70, 0);
        step();
        step();
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/output_forward.md
Name: output_forward

Overview:
- Forward-pass output neuron: multiply-accumulates N_HIDDEN hidden activations against their output-layer weights, one pair per handshake beat, and produces a registered unsigned sum.
- The result feeds the backprop weight-update stage as its final value, so the ACC_WIDTH default matches that 23-bit input.
- Sits between the hidden-layer neurons and the backprop stage; started by the sequencer's forward-pass strobe.

Parameters:
- N_HIDDEN, 4, number of hidden value/weight pairs accumulated per pass (>=1).
- H_WIDTH, 10, hidden activation width (unsigned).
- W_WIDTH, 8, weight width (unsigned).
- ACC_WIDTH, 23, accumulator and result width (unsigned, saturating).

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  begin a forward pass; sampled only in IDLE.
- clear_i  in  1  synchronous abort: returns to IDLE, acc=0, cnt=0; final_o and sat_o are kept.
- valid_i  in  1  hidden_val_i/w_i beat valid.
- hidden_val_i  in  H_WIDTH  hidden activation for the current beat.
- w_i  in  W_WIDTH  weight for the current beat.
- ready_o  out  1  block accepts a beat (high only in ACCUM).
- busy_o  out  1  state != IDLE.
- final_o  out  ACC_WIDTH  last completed sum; held until the next completion.
- done_o  out  1  one-cycle pulse, high while in DONE.
- sat_o  out  1  sticky saturation flag for the current/last pass.

Behaviour:
- Reset (rst_i=0, async): state=IDLE, acc=0, cnt=0, final_o=0, done_o=0, sat_o=0, ready_o=0, busy_o=0. This applies mid-pass too; any partial sum is discarded.
- Priority, highest first: rst_i, clear_i, FSM.
- States and transitions:
  - IDLE: ready_o=0. On start_i=1: acc=0 (or bias, see the optional feature), cnt=0, sat_o=0, go to ACCUM.
  - ACCUM: ready_o=1. A beat is accepted when valid_i & ready_o. On accept: acc <= sat(acc + hidden_val_i*w_i) and cnt <= cnt+1. If this accept is beat N_HIDDEN-1, then final_o <= the same saturated sum and the state goes to DONE. With valid_i=0 the block holds and does not time out. start_i is ignored in this state.
  - DONE: done_o=1 for exactly one cycle, ready_o=0, then IDLE. A start_i in DONE is ignored; it must be re-asserted in IDLE.
- Arithmetic:
  - The product is H_WIDTH+W_WIDTH bits, zero-extended.
  - The sum is computed at ACC_WIDTH+1 bits. If bit ACC_WIDTH is set, acc clamps to 2^ACC_WIDTH-1 and sat_o <= 1.
  - Once clamped, acc stays at the maximum for the rest of the pass.
- Latency: start_i seen at edge 0. With valid_i held high, beats are accepted on edges 1..N_HIDDEN. done_o and the new final_o are visible in the cycle after edge N_HIDDEN. Total is N_HIDDEN+1 cycles from start to done.
- cnt width is clog2(N_HIDDEN)+1; there is no wrap within a pass.
- A clear_i in the same cycle as an accepted last beat wins: no DONE, final_o unchanged.

Optional Feature:
- Macro OUTPUT_FORWARD_BIAS_EN.
- Defined: adds input port bias_i (W_WIDTH). On start_i in IDLE, acc is initialised to bias_i (zero-extended) instead of 0; saturation rules are unchanged.
- Undefined: no bias_i port; acc starts at 0.

Test Plan:
- Defaults, valid_i held high, h={1,2,3,4}, w={5,6,7,8} -> done_o pulses 5 cycles after start, final_o=70, sat_o=0.
- Same data with valid_i low for 2 cycles between beats 1 and 2 -> ready_o stays high, cnt holds, final_o=70, done 7 cycles after start.
- ACC_WIDTH=20, N_HIDDEN=8, all h=1023, w=255 -> final_o=1048575, sat_o=1. The next pass with h=w=0 gives final_o=0, sat_o=0.
- clear_i asserted after beat 2 -> IDLE next cycle, no done_o, final_o keeps the previous value. A fresh pass with the first test's data then returns 70.
- rst_i pulsed low mid-ACCUM -> all outputs 0 immediately (asynchronously). start_i in ACCUM/DONE is ignored, which a bench checks by confirming no restart occurs.
- OUTPUT_FORWARD_BIAS_EN defined, bias_i=10, first test's data -> final_o=80.
